// File: rtl/float_add_pipe.sv
// float_add_pipe: 3-stage IEEE-754 add/sub (S1 swap/align, S2 magnitude add, S3 normalise/round/pack).
// Define FADD_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates toward zero.
module float_add_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] c,
  output logic                  ovf
);
  localparam int EXP_W  = (DATA_WIDTH == 16) ? 5 : (DATA_WIDTH == 64) ? 11 : 8;
  localparam int MAN_W  = (DATA_WIDTH == 16) ? 10 : (DATA_WIDTH == 64) ? 52 : 23;
  localparam int MW     = MAN_W + 4;
  localparam int XW     = EXP_W + 2;
  localparam int LZW    = $clog2(MW + 1);
  localparam int STAGES = 3;
  localparam logic [EXP_W-1:0]     SH_MAX = EXP_W'(MAN_W + 3);
  localparam logic signed [XW-1:0] E_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] E_ONE  = XW'(1);

  logic [STAGES:1] vld_pipe;
  logic            advance;

  assign advance   = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  // S1: unpack with denormal flush, order by magnitude, align smaller operand
  logic             sa, sb, swap;
  logic [EXP_W-1:0] ea, eb, el, es, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [MW-1:0]    ml, ms, ms_sh, al;

  always_comb begin
    sa    = a[DATA_WIDTH-1];
    sb    = b[DATA_WIDTH-1] ^ op_sub;
    ea    = a[DATA_WIDTH-2:MAN_W];
    eb    = b[DATA_WIDTH-2:MAN_W];
    fa    = (ea == '0) ? '0 : a[MAN_W-1:0];
    fb    = (eb == '0) ? '0 : b[MAN_W-1:0];
    swap  = {eb, fb} > {ea, fa};
    el    = swap ? eb : ea;
    es    = swap ? ea : eb;
    ml    = {el != '0, swap ? fb : fa, 3'b000};
    ms    = {es != '0, swap ? fa : fb, 3'b000};
    diff  = el - es;
    ms_sh = '0;
    if (diff >= SH_MAX) begin
      al = {{(MW-1){1'b0}}, |ms};
    end else begin
      ms_sh = ms >> diff;
      // everything shifted below the round bit collapses into sticky
      al = {ms_sh[MW-1:1], ms_sh[0] | ((ms & ((MW'(1) << diff) - MW'(1))) != '0)};
    end
  end

  logic             s1_sign, s1_sub, s1_zsign, s2_sign, s2_zsign;
  logic [EXP_W-1:0] s1_exp, s2_exp;
  logic [MW-1:0]    s1_ml, s1_ms;
  logic [MW:0]      s2_sum;

  always_ff @(posedge clk) begin
    if (rst)          vld_pipe <= '0;
    else if (advance) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign  <= swap ? sb : sa;
      s1_sub   <= sa ^ sb;
      s1_zsign <= sa & sb;
      s1_exp   <= el;
      s1_ml    <= ml;
      s1_ms    <= al;
      s2_sign  <= s1_sign;
      s2_zsign <= s1_zsign;
      s2_exp   <= s1_exp;
      s2_sum   <= s1_sub ? ({1'b0, s1_ml} - {1'b0, s1_ms}) : ({1'b0, s1_ml} + {1'b0, s1_ms});
    end
  end

  // S3: normalise, round, pack
  logic [LZW-1:0]        lz;
  logic                  found;
  logic signed [XW-1:0]  en, er;
  logic [MW-1:0]         mn;
  logic [MAN_W+1:0]      rnd;
  logic [MAN_W:0]        mr;
  logic [DATA_WIDTH-1:0] res;
  logic                  res_ovf;
  logic                  unused;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (s2_sum[i]) found = 1'b1;
        else           lz = lz + LZW'(1);
      end
    end
    if (s2_sum[MW]) begin
      mn = {s2_sum[MW:2], s2_sum[1] | s2_sum[0]};
      en = XW'(s2_exp) + E_ONE;
    end else begin
      mn = s2_sum[MW-1:0] << lz;
      en = XW'(s2_exp) - XW'(lz);
    end
`ifdef FADD_ROUND_NEAREST_EN
    rnd = {1'b0, mn[MW-1:3]} + (MAN_W+2)'(mn[2] & (mn[1] | mn[0] | mn[3]));
`else
    rnd = {1'b0, mn[MW-1:3]};
`endif
    if (rnd[MAN_W+1]) begin
      mr = rnd[MAN_W+1:1];
      er = en + E_ONE;
    end else begin
      mr = rnd[MAN_W:0];
      er = en;
    end
    res_ovf = 1'b0;
    // a zero sum with both signs negative can only come from -0 + -0
    if (s2_sum == '0) begin
      res = {s2_zsign, {(DATA_WIDTH-1){1'b0}}};
    end else if (er >= E_MAX) begin
      res     = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
    end else if (er < E_ONE) begin
      res = {s2_sign, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      res = {s2_sign, er[EXP_W-1:0], mr[MAN_W-1:0]};
    end
  end

  assign unused = ^{mr[MAN_W], mn[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      c   <= '0;
      ovf <= 1'b0;
    end else if (advance) begin
      c   <= res;
      ovf <= res_ovf;
    end
  end
endmodule

// File: doc/float_add_pipe.md
FLOAT_ADD_PIPE -- requirements
Module: float_add_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; legal values 16, 32, 64.
REQ-002 SHALL derive EXP_W as 5/8/11 and MAN_W as 10/23/52 for DATA_WIDTH 16/32/64.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit, operands valid.
REQ-007 SHALL have port in_ready, output, 1 bit, block accepts operands.
REQ-008 SHALL have port op_sub, input, 1 bit, 0 = A+B, 1 = A-B.
REQ-009 SHALL have port a, input, DATA_WIDTH bits, IEEE-754 operand A.
REQ-010 SHALL have port b, input, DATA_WIDTH bits, IEEE-754 operand B.
REQ-011 SHALL have port out_valid, output, 1 bit, result valid.
REQ-012 SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-013 SHALL have port c, output, DATA_WIDTH bits, IEEE-754 result.
REQ-014 SHALL have port ovf, output, 1 bit, result overflowed to infinity; qualified by out_valid.

Function
REQ-015 SHALL transfer an input when in_valid && in_ready at a rising clk edge, and an output when out_valid && out_ready.
REQ-016 SHALL be a 3-stage pipeline: S1 unpack, swap so |A| >= |B|, align; S2 add/subtract magnitudes; S3 normalise, round, pack.
REQ-017 SHALL present the result of an accepted input on c/out_valid exactly 3 cycles after acceptance when out_ready is held high.
REQ-018 SHALL sustain one accepted input per cycle when out_ready is held high.
REQ-019 SHALL stall all stages together: advance = !out_valid || out_ready; in_ready = advance.
REQ-020 SHALL hold c, ovf and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL treat op_sub = 1 as inverting the sign of b before the operation.
REQ-022 SHALL flush denormal inputs (exponent 0) to signed zero.
REQ-023 SHALL return the other operand unchanged, with effective sign, when one operand is zero; both zero -> +0 unless both effective signs are negative (-0).
REQ-024 SHALL return +0 on exact cancellation.
REQ-025 SHALL align with a right shift of (expA - expB); shifts >= MAN_W+3 leave only the sticky bit.
REQ-026 SHALL, on mantissa carry-out, shift right 1 and increment the exponent; on leading zeros, shift left to the leading one and decrement the exponent.
REQ-027 SHALL output signed zero when the normalised exponent is < 1.
REQ-028 SHALL output signed infinity and assert ovf when the exponent reaches all-ones after normalise/round.
REQ-029 SHALL leave NaN/infinity inputs outside scope; the output for such inputs is undefined but SHALL NOT corrupt other pipeline slots.

Reset
REQ-030 SHALL, on rst high at a clk edge, clear out_valid, ovf, c, and all stage valid bits to 0.
REQ-031 SHALL discard in-flight operations on reset mid-operation; in_ready is 1 in the first cycle after reset.

Configuration
REQ-032 SHALL use macro FADD_ROUND_NEAREST_EN: when defined, round to nearest, ties to even, using guard/round/sticky bits, with rounding carry renormalised.
REQ-033 SHALL, without FADD_ROUND_NEAREST_EN, truncate and discard shifted-out bits (round toward zero).

Verification (DATA_WIDTH = 32)
REQ-034 SHALL test a = 0x3F800000, b = 0x3F800000, op_sub = 0 -> c = 0x40000000, ovf = 0, 3 cycles later.
REQ-035 SHALL test a = 0x40400000, b = 0x3F800000, op_sub = 1 -> 0x40000000; a = 0x3F800000, b = 0xBF800000, op_sub = 0 -> 0x00000000.
REQ-036 SHALL test a = b = 0x7F7FFFFF -> c = 0x7F800000, ovf = 1.
REQ-037 SHALL test a = 0x3F800001, b = 0x33800000 -> 0x3F800002 with the macro, 0x3F800001 without; a = 0x3F800000, b = 0x33800000 -> 0x3F800000 in both builds.
REQ-038 SHALL test 8 back-to-back inputs with out_ready low for cycles 2-5 -> no result lost or duplicated, in order, and in_ready low while stalled.
REQ-039 SHALL test rst pulsed with 2 operations in flight -> no out_valid afterwards until new input, which completes in 3 cycles.
